// File: rtl/crc_fwd_pkg.sv
// Shared types for the CRC-gated frame forwarder: reader FSM states, parameter defaults
// and the descriptor layout carried between the frame writer and the reader.
package crc_fwd_pkg;

    localparam int unsigned MaxLenDefault = 1521;
    localparam int unsigned IfgDefault    = 12;
    localparam int unsigned LenW          = 11;
    localparam int unsigned DescW         = LenW + 1;

    typedef struct packed {
        logic [LenW-1:0] len;
        logic            trunc;
    } desc_t;

    typedef enum logic [2:0] {
        StDrain,
        StIdle,
        StForward,
        StDiscard,
        StGap
    } state_e;

endpackage

// File: rtl/crc_fwd_ctrl_if.sv
// Frame, CRC verdict, external data FIFO and statistics signals of crc_fwd_ctrl.
interface crc_fwd_ctrl_if;

    logic        eth_strobe;
    logic        crc_valid;
    logic        crc_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic        data_we;
    logic        data_re;
    logic        out_strobe;
    logic        err;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    modport master (
        output eth_strobe, crc_valid, crc_ok, fifo_full, fifo_empty,
        input  data_we, data_re, out_strobe, err, frames_ok, frames_bad
    );

    modport slave (
        input  eth_strobe, crc_valid, crc_ok, fifo_full, fifo_empty,
        output data_we, data_re, out_strobe, err, frames_ok, frames_bad
    );

endinterface

// File: rtl/fifo_1c.sv
// Single-clock FIFO of depth 2**AW; push while full is accepted only alongside a pop.
module fifo_1c #(
    parameter int unsigned DW = 1,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW:0] DepthW = Depth[AW:0];

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == DepthW);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/crc_fwd_ctrl.sv
// Buffers frames into an external FIFO and forwards or discards each one on its CRC verdict.
// Define CRC_FWD_STATS_EN to enable the frames_ok/frames_bad counters.
module crc_fwd_ctrl
    import crc_fwd_pkg::*;
#(
    parameter int unsigned MAX_LEN = MaxLenDefault,
    parameter int unsigned IFG     = IfgDefault,
    parameter int unsigned DESC_AW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    crc_fwd_ctrl_if.slave  bus
);

    localparam logic [LenW-1:0] MaxLenW = LenW'(MAX_LEN);
    // GAP plus the IDLE decision cycle give IFG quiet cycles on out_strobe.
    localparam logic [15:0] GapLast = (IFG > 1) ? 16'(IFG - 2) : 16'd0;

    logic            strobe_q, in_frame_q, in_frame_d, trunc_q, trunc_d;
    logic [LenW-1:0] len_q, len_d, cur_len_q, cur_len_d;
    logic            rise, fall, at_max, data_we, data_re;
    logic [DescW-1:0] desc_wr_raw, desc_rd_raw;
    desc_t           desc_wr, desc_rd;
    logic            desc_full, desc_empty, desc_pop;
    logic            verd_rd, verd_full, verd_empty;
    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            rst_done_q, out_strobe_q, err_q;

    always_comb begin
        rise       = bus.eth_strobe & ~strobe_q;
        fall       = ~bus.eth_strobe & in_frame_q;
        at_max     = in_frame_q & (len_q == MaxLenW);
        in_frame_d = in_frame_q;
        len_d      = len_q;
        trunc_d    = trunc_q;
        if (rise) begin
            in_frame_d = 1'b1;
            len_d      = LenW'(1);
            trunc_d    = bus.fifo_full;
        end else if (fall) begin
            in_frame_d = 1'b0;
        end else if (in_frame_q && bus.eth_strobe) begin
            trunc_d = trunc_q | bus.fifo_full;
            if (!at_max) len_d = len_q + LenW'(1);
        end
        data_we       = (rise | (in_frame_q & bus.eth_strobe & ~at_max)) & ~bus.fifo_full;
        desc_wr.len   = len_q;
        desc_wr.trunc = trunc_q | (len_q == MaxLenW);
    end

    assign desc_wr_raw = desc_wr;
    assign desc_rd     = desc_t'(desc_rd_raw);

    fifo_1c #(.DW(DescW), .AW(DESC_AW)) u_desc_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fall),
        .wdata (desc_wr_raw),
        .pop   (desc_pop),
        .rdata (desc_rd_raw),
        .full  (desc_full),
        .empty (desc_empty)
    );

    fifo_1c #(.DW(1), .AW(DESC_AW)) u_verd_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.crc_valid),
        .wdata (bus.crc_ok),
        .pop   (desc_pop),
        .rdata (verd_rd),
        .full  (verd_full),
        .empty (verd_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_len_d = cur_len_q;
        data_re   = 1'b0;
        desc_pop  = 1'b0;
        unique case (state_q)
            StDrain: begin
                // rst_done_q keeps data_re low while reset is still asserted.
                if (rst_done_q) begin
                    if (!bus.fifo_empty) data_re = 1'b1;
                    else                 state_d = StIdle;
                end
            end
            StIdle: begin
                if (!desc_empty && !verd_empty) begin
                    desc_pop  = 1'b1;
                    cur_len_d = desc_rd.len;
                    cnt_d     = '0;
                    state_d   = (verd_rd && !desc_rd.trunc) ? StForward : StDiscard;
                end
            end
            StForward, StDiscard: begin
                data_re = 1'b1;
                if (cnt_q + 16'd1 == 16'(cur_len_q)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q >= GapLast) state_d = StIdle;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q     <= 1'b1;  // a frame already running at release is not a rising edge
            in_frame_q   <= 1'b0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            state_q      <= StDrain;
            cnt_q        <= '0;
            cur_len_q    <= '0;
            rst_done_q   <= 1'b0;
            out_strobe_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            strobe_q     <= bus.eth_strobe;
            in_frame_q   <= in_frame_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_len_q    <= cur_len_d;
            rst_done_q   <= 1'b1;
            out_strobe_q <= data_re & (state_q == StForward);
            err_q        <= err_q | (fall & desc_full & ~desc_pop)
                                  | (bus.crc_valid & verd_full & ~desc_pop)
                                  | (data_re & bus.fifo_empty);
        end
    end

    assign bus.data_we    = data_we;
    assign bus.data_re    = data_re;
    assign bus.out_strobe = out_strobe_q;
    assign bus.err        = err_q;

`ifdef CRC_FWD_STATS_EN
    logic        enter_fwd, enter_dis;
    logic [15:0] frames_ok_q, frames_bad_q;

    assign enter_fwd = (state_q == StIdle) & (state_d == StForward);
    assign enter_dis = (state_q == StIdle) & (state_d == StDiscard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            if (enter_fwd && frames_ok_q != 16'hFFFF)  frames_ok_q  <= frames_ok_q + 16'd1;
            if (enter_dis && frames_bad_q != 16'hFFFF) frames_bad_q <= frames_bad_q + 16'd1;
        end
    end

    assign bus.frames_ok  = frames_ok_q;
    assign bus.frames_bad = frames_bad_q;
`else
    assign bus.frames_ok  = '0;
    assign bus.frames_bad = '0;
`endif

endmodule

// File: tb/tb_crc_fwd_ctrl.sv
// Directed and randomized frames against crc_fwd_ctrl with a modelled external data FIFO.
module tb_crc_fwd_ctrl;

    localparam int unsigned MaxLen    = 1521;
    localparam int unsigned Ifg       = 12;
    localparam int unsigned DescAw    = 2;
    localparam int          FifoDepth = 4096;
`ifdef CRC_FWD_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    crc_fwd_ctrl_if bus ();

    crc_fwd_ctrl #(.MAX_LEN(MaxLen), .IFG(Ifg), .DESC_AW(DescAw)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External data FIFO: occupancy only; it survives DUT reset.
    int fifo_cnt = 0;
    assign bus.fifo_empty = (fifo_cnt == 0);
    assign bus.fifo_full  = (fifo_cnt >= FifoDepth);
    always @(posedge clk) begin
        fifo_cnt <= fifo_cnt + (bus.data_we ? 1 : 0) - ((bus.data_re && fifo_cnt > 0) ? 1 : 0);
    end

    int cyc = 0, n_we = 0, n_re = 0, n_out = 0;
    int vc_cyc = 0, run_cyc = 0, last_gap = -1, last_out_end = -1;
    bit prev_out = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.data_we) n_we <= n_we + 1;
        if (bus.data_re) n_re <= n_re + 1;
        if (bus.crc_valid) vc_cyc <= cyc + 1;
        if (bus.out_strobe) begin
            n_out <= n_out + 1;
            if (!prev_out) begin
                run_cyc <= cyc + 1;
                if (last_out_end >= 0) last_gap <= cyc - last_out_end;
            end
            last_out_end <= cyc + 1;
        end
        prev_out <= bus.out_strobe;
    end

    int n_cmp = 0, n_bad = 0;
    int b_we, b_re, b_out;
    int exp_ok = 0, exp_bad = 0, e_we, e_re, e_out, len;
    bit ok;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_we  = n_we;
        b_re  = n_re;
        b_out = n_out;
    endtask

    task automatic send_frame(input int flen, input bit vok, input bit give_verdict);
        for (int i = 0; i < flen; i++) begin
            @(posedge clk); #1 bus.eth_strobe = 1'b1;
        end
        @(posedge clk); #1 bus.eth_strobe = 1'b0;
        if (give_verdict) begin
            @(posedge clk); #1 bus.crc_valid = 1'b1; bus.crc_ok = vok;
            @(posedge clk); #1 bus.crc_valid = 1'b0; bus.crc_ok = 1'b0;
        end
    endtask

    // Model: a frame occupies min(len, MaxLen) FIFO words and is forwarded only if the
    // verdict is good and it never reached MaxLen.
    function automatic int beats(input int flen);
        return (flen < MaxLen) ? flen : MaxLen;
    endfunction

    function automatic bit forwarded(input int flen, input bit vok);
        return vok && (flen < MaxLen);
    endfunction

    task automatic check_stats(input string tag);
        check({tag, "_frames_ok"},  int'(bus.frames_ok),  StatsEn ? exp_ok : 0);
        check({tag, "_frames_bad"}, int'(bus.frames_bad), StatsEn ? exp_bad : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.eth_strobe = 1'b0;
        bus.crc_valid  = 1'b0;
        bus.crc_ok     = 1'b0;
        #2 rst_n = 1'b0;
        idle(3);
        check("rst_data_we", int'(bus.data_we), 0);
        check("rst_data_re", int'(bus.data_re), 0);
        check("rst_out_strobe", int'(bus.out_strobe), 0);
        check("rst_err", int'(bus.err), 0);
        check_stats("rst");
        rst_n = 1'b1;
        idle(4);

        // Good 64-cycle frame, with verdict-to-out_strobe latency.
        snap();
        send_frame(64, 1'b1, 1'b1);
        idle(64 + Ifg + 8);
        exp_ok++;
        check("good64_we", n_we - b_we, 64);
        check("good64_re", n_re - b_re, 64);
        check("good64_out", n_out - b_out, 64);
        check("good64_latency", run_cyc - vc_cyc, 3);
        check_stats("good64");

        // Bad-CRC 64-cycle frame is read out but never strobed.
        snap();
        send_frame(64, 1'b0, 1'b1);
        idle(64 + Ifg + 8);
        exp_bad++;
        check("bad64_re", n_re - b_re, 64);
        check("bad64_out", n_out - b_out, 0);
        check_stats("bad64");

        // Random frames and verdicts.
        snap();
        e_we = 0; e_re = 0; e_out = 0;
        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(1, 120));
            ok  = 1'($urandom_range(0, 1));
            send_frame(len, ok, 1'b1);
            idle(len + Ifg + 8);
            e_we += beats(len);
            e_re += beats(len);
            if (forwarded(len, ok)) begin
                e_out += len;
                exp_ok++;
            end else begin
                exp_bad++;
            end
        end
        check("rand_we", n_we - b_we, e_we);
        check("rand_re", n_re - b_re, e_re);
        check("rand_out", n_out - b_out, e_out);
        check_stats("rand");
        check("rand_err", int'(bus.err), 0);

        // Two ready frames: inter-frame gap on out_strobe.
        snap();
        send_frame(20, 1'b1, 1'b1);
        send_frame(20, 1'b1, 1'b1);
        idle(40 + 2 * Ifg + 12);
        exp_ok += 2;
        check("b2b_out", n_out - b_out, 40);
        check("b2b_gap", last_gap, Ifg);

        // Over-length strobe: capped writes, truncated, discarded.
        snap();
        send_frame(1600, 1'b1, 1'b1);
        idle(MaxLen + Ifg + 10);
        exp_bad++;
        check("long_we", n_we - b_we, MaxLen);
        check("long_re", n_re - b_re, MaxLen);
        check("long_out", n_out - b_out, 0);
        check_stats("long");
        check("long_err", int'(bus.err), 0);

        // Reset released while eth_strobe is already high: that frame is ignored.
        rst_n = 1'b0;
        bus.eth_strobe = 1'b1;
        idle(3);
        rst_n = 1'b1;
        exp_ok = 0; exp_bad = 0;
        snap();
        idle(10);
        bus.eth_strobe = 1'b0;
        idle(Ifg + 20);
        check("midframe_we", n_we - b_we, 0);
        check("midframe_re", n_re - b_re, 0);

        // Reset in the middle of forwarding with 30 words left in the FIFO.
        snap();
        send_frame(60, 1'b1, 1'b1);
        for (int i = 0; i < 500 && (n_re - b_re) < 30; i++) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_fwd_data_re", int'(bus.data_re), 0);
        check("rst_fwd_out", int'(bus.out_strobe), 0);
        exp_ok = 0; exp_bad = 0;
        check_stats("rst_fwd");
        @(posedge clk); #1 rst_n = 1'b1;
        snap();
        for (int i = 0; i < 200 && fifo_cnt != 0; i++) @(posedge clk);
        idle(4);
        check("drain_re", n_re - b_re, 30);
        check("drain_out", n_out - b_out, 0);
        check("drain_empty", fifo_cnt, 0);
        snap();
        send_frame(16, 1'b1, 1'b1);
        idle(16 + Ifg + 8);
        exp_ok++;
        check("post_drain_out", n_out - b_out, 16);
        check_stats("post_drain");
        check("post_drain_err", int'(bus.err), 0);

        // Verdicts withheld: the fifth descriptor overflows the queue.
        snap();
        for (int k = 0; k < 4; k++) send_frame(8, 1'b0, 1'b0);
        idle(2);
        check("ovf4_err", int'(bus.err), 0);
        send_frame(8, 1'b0, 1'b0);
        idle(4);
        check("ovf5_err", int'(bus.err), 1);
        check("ovf_we", n_we - b_we, 40);
        check("ovf_re", n_re - b_re, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
